// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bundle: NUM_REQ producers plus the arbitrated write beat.
// The arbiter takes the slave side; producers and the FIFO view the master side.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            gnt;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          preempt;

    modport master (
        output req, req_last, req_data, full,
        input  ack, gnt, w_en, data_in, preempt
    );

    modport slave (
        input  req, req_last, req_data, full,
        output ack, gnt, w_en, data_in, preempt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port.
// One beat per cycle from the registered owner; MAX_BURST caps each grant.

module fifo_wr_arbiter_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sel,
    input  logic                  req,
    input  logic                  last,
    input  logic                  full,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  beat,
    output logic                  withdraw,
    output logic                  last_beat,
    output logic [DATA_WIDTH-1:0] data_o
);
    assign beat      = sel & req & ~full;
    assign withdraw  = sel & ~req;
    assign last_beat = beat & last;
    // Non-owners contribute zero so the top can OR-reduce the lanes.
    assign data_o    = sel ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic wclk,
    input  logic wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                             state;
    logic [OW-1:0]                      owner;
    logic [OW-1:0]                      last_owner;
    logic [CW-1:0]                      beat_cnt;
    logic                               preempt_q;

    logic [NUM_REQ-1:0]                 sel;
    logic [NUM_REQ-1:0]                 beat_vec;
    logic [NUM_REQ-1:0]                 wd_vec;
    logic [NUM_REQ-1:0]                 last_vec;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0]              data_mux;
    logic [OW-1:0]                      nxt_owner;
    logic [OW-1:0]                      scan_idx;
    logic                               found;
    logic                               beat;
    logic                               own_last;
    logic                               withdraw;
    logic                               cap_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign sel[gi] = (state == BURST) && (owner == OW'(gi));
            fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .sel       (sel[gi]),
                .req       (bus.req[gi]),
                .last      (bus.req_last[gi]),
                .full      (bus.full),
                .data      (bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .beat      (beat_vec[gi]),
                .withdraw  (wd_vec[gi]),
                .last_beat (last_vec[gi]),
                .data_o    (lane_data[gi])
            );
        end
    endgenerate

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) data_mux = data_mux | lane_data[i];
    end

    assign beat     = |beat_vec;
    assign own_last = |last_vec;
    assign withdraw = |wd_vec;
    assign cap_hit  = (beat_cnt == CW'(MAX_BURST - 1));

    // Scan starts just past the previous owner, so the last winner is checked last.
    always_comb begin
        nxt_owner = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = OW'((int'(last_owner) + k) % NUM_REQ);
            if (!found && bus.req[scan_idx]) begin
                found     = 1'b1;
                nxt_owner = scan_idx;
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= nxt_owner;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (withdraw || (beat && (own_last || cap_hit))) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        // A cap hit on a beat that is also last is a normal end.
                        preempt_q  <= beat & cap_hit & ~own_last;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = sel;
    assign bus.ack     = beat_vec;
    assign bus.w_en    = beat;
    assign bus.data_in = data_mux;
    assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat queues drive the bus,
// a scoreboard of expected {ack, data} beats is checked on every write.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(16)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    logic [8:0]  rq [NR][$];
    logic [11:0] sb [$];
    logic [NR-1:0] ack_seen;
    logic full_v;
    int errors = 0;
    int checks = 0;
    int pre_cnt, pre_at, wr_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int id, input int idx);
        logic [1:0] i2;
        logic [5:0] x6;
        i2 = id[1:0];
        x6 = idx[5:0];
        return {i2, x6};
    endfunction

    task automatic load(input int id, input int n, input int base, input bit last_end);
        for (int k = 0; k < n; k++)
            rq[id].push_back({(last_end && k == n - 1), dat(id, base + k)});
    endtask

    task automatic expect_beats(input int id, input int base, input int n);
        logic [3:0] oh;
        for (int k = 0; k < n; k++) begin
            oh = 4'b0001 << id;
            sb.push_back({oh, dat(id, base + k)});
        end
    endtask

    task automatic drive();
        logic [NR-1:0] r, l;
        logic [NR*DW-1:0] d;
        r = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                r[i] = 1'b1;
                l[i] = rq[i][0][8];
                d[i*DW +: DW] = rq[i][0][7:0];
            end
        end
        bus.req = r;
        bus.req_last = l;
        bus.req_data = d;
        bus.full = full_v;
    endtask

    task automatic sample();
        logic [11:0] e;
        ack_seen = bus.ack;
        if (bus.preempt) begin
            pre_cnt++;
            pre_at = wr_cnt;
        end
        if (bus.w_en) begin
            wr_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=beat %0h expected=no beat", {bus.ack, bus.data_in});
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat", {20'd0, bus.ack, bus.data_in}, {20'd0, e});
            end
        end
    endtask

    // Commit the beat acked before this edge, then present the next beats.
    task automatic cyc();
        @(posedge wclk); #1;
        for (int i = 0; i < NR; i++)
            if (ack_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive();
        @(negedge wclk);
        sample();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic rst_dut();
        wrst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        sb.delete();
        ack_seen = '0;
        full_v = 1'b0;
        drive();
        @(posedge wclk); #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_wen", bus.w_en, 0);
        chk("rst_data", bus.data_in, 0);
        chk("rst_preempt", bus.preempt, 0);
        wrst = 1'b0;
        pre_cnt = 0; pre_at = 0; wr_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g [5];
        logic       exp_w [5];
        int n;
        full_v = 1'b0;
        ack_seen = '0;

        // 1) single requester, 3-beat burst
        rst_dut();
        load(0, 3, 0, 1'b1);
        expect_beats(0, 0, 3);
        exp_g = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        exp_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("t1_gnt%0d", c), bus.gnt, exp_g[c]);
            chk($sformatf("t1_wen%0d", c), bus.w_en, exp_w[c]);
        end
        chk("t1_sb", sb.size(), 0);

        // 2) all requesters single-beat, req0 twice: order 0,1,2,3,0
        rst_dut();
        rq[0].push_back({1'b1, dat(0, 0)});
        rq[0].push_back({1'b1, dat(0, 1)});
        for (int i = 1; i < NR; i++) load(i, 1, 0, 1'b1);
        expect_beats(0, 0, 1);
        expect_beats(1, 0, 1);
        expect_beats(2, 0, 1);
        expect_beats(3, 0, 1);
        expect_beats(0, 1, 1);
        drain(60);

        // 3) req0 streams 40, req2 waits: cap at 16, handover, resume
        rst_dut();
        load(0, 40, 0, 1'b1);
        load(2, 3, 0, 1'b1);
        expect_beats(0, 0, 16);
        expect_beats(2, 0, 3);
        expect_beats(0, 16, 16);
        expect_beats(0, 32, 8);
        drain(200);
        chk("t3_preempts", pre_cnt, 2);
        chk("t3_preempt_at", pre_at, 35);

        // 4) full for 5 cycles mid-burst; cap still lands after 16 written beats
        rst_dut();
        load(1, 18, 0, 1'b1);
        expect_beats(1, 0, 18);
        n = 0;
        while (rq[1].size() != 15 && n < 50) begin cyc(); n++; end
        chk("t4_reach", rq[1].size(), 15);
        full_v = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("t4_wen%0d", c), bus.w_en, 0);
            chk($sformatf("t4_ack%0d", c), bus.ack, 0);
            chk($sformatf("t4_gnt%0d", c), bus.gnt, 4'b0010);
        end
        full_v = 1'b0;
        drain(100);
        chk("t4_preempts", pre_cnt, 1);
        chk("t4_preempt_at", pre_at, 16);

        // 5) owner withdraws after 2 beats without last; req3 next
        rst_dut();
        load(1, 2, 0, 1'b0);
        load(3, 1, 0, 1'b1);
        expect_beats(1, 0, 2);
        expect_beats(3, 0, 1);
        n = 0;
        while (rq[1].size() != 0 && n < 50) begin cyc(); n++; end
        chk("t5_wd_gnt", bus.gnt, 4'b0010);
        chk("t5_wd_wen", bus.w_en, 0);
        cyc();
        chk("t5_idle_gnt", bus.gnt, 4'b0000);
        cyc();
        chk("t5_next_gnt", bus.gnt, 4'b1000);
        chk("t5_next_wen", bus.w_en, 1);
        drain(20);
        chk("t5_preempts", pre_cnt, 0);

        // 6) reset during beat 4; afterwards req0 must beat req3
        load(0, 1, 0, 1'b1);
        expect_beats(0, 0, 1);
        drain(20);
        load(2, 6, 0, 1'b1);
        expect_beats(2, 0, 6);
        n = 0;
        while (rq[2].size() != 3 && n < 50) begin cyc(); n++; end
        chk("t6_beat4_wen", bus.w_en, 1);
        #2 wrst = 1'b1;
        #1;
        chk("t6_gnt", bus.gnt, 0);
        chk("t6_ack", bus.ack, 0);
        chk("t6_wen", bus.w_en, 0);
        chk("t6_data", bus.data_in, 0);
        chk("t6_preempt", bus.preempt, 0);
        for (int i = 0; i < NR; i++) rq[i].delete();
        sb.delete();
        ack_seen = '0;
        drive();
        @(posedge wclk); #1;
        wrst = 1'b0;
        load(3, 1, 0, 1'b1);
        load(0, 1, 5, 1'b1);
        expect_beats(0, 5, 1);
        expect_beats(3, 0, 1);
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
